// File: rtl/meduram_pkg.sv
// Shared types and helpers for the meduram write-port logic.
package meduram_pkg;

    localparam int MAX_WRAGENT = 8;

    typedef enum logic {
        INIT,
        RUN
    } wrarb_state_t;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int agent_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/meduram_rr_arbiter.sv
// Round-robin arbiter: one-hot grant and index searched upward from a
// registered pointer that moves past whichever agent actually transferred.
module meduram_rr_arbiter
    import meduram_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = agent_width(N)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] advance_idx,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;

    // The caller supplies the transferring index so an external override
    // (e.g. a lock) still leaves the pointer just past the real winner.
    always_comb begin
        ptr_next = ptr_reg;
        if (advance) begin
            ptr_next = (advance_idx == IW'(N - 1)) ? '0 : advance_idx + IW'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    always_comb begin
        int c;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr_reg) + k;
            if (c >= N) begin
                c = c - N;
            end
            if (!grant_any && req[c]) begin
                grant_any = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = IW'(c);
            end
        end
    end

endmodule

// File: rtl/meduram_wrarb.sv
// Write-port arbiter and zero-sweep initializer for one meduram bank.
// Optional MEDURAM_WRARB_LOCK_EN adds req_lock to hold the port for one agent.
module meduram_wrarb
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_DEPTH   = 2 ** ADDR_WIDTH,
    parameter int NB_WRAGENT  = 2,
    parameter int AGENT_WIDTH = agent_width(NB_WRAGENT)
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             clear,
    input  logic [NB_WRAGENT-1:0]            req_valid,
    output logic [NB_WRAGENT-1:0]            req_ready,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] req_addr,
    input  logic [NB_WRAGENT*DATA_WIDTH-1:0] req_data,
`ifdef MEDURAM_WRARB_LOCK_EN
    input  logic [NB_WRAGENT-1:0]            req_lock,
`endif
    output logic                             mem_wren,
    output logic [ADDR_WIDTH-1:0]            mem_wraddr,
    output logic [DATA_WIDTH-1:0]            mem_wrdata,
    output logic [AGENT_WIDTH-1:0]           mem_agent,
    output logic                             init_done
);

    wrarb_state_t state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  counter_reg;
    logic                   init_done_reg;
    logic                   mem_wren_reg;
    logic [ADDR_WIDTH-1:0]  mem_wraddr_reg;
    logic [DATA_WIDTH-1:0]  mem_wrdata_reg;
    logic [AGENT_WIDTH-1:0] mem_agent_reg;

    logic [ADDR_WIDTH-1:0]  addr_arr [NB_WRAGENT];
    logic [DATA_WIDTH-1:0]  data_arr [NB_WRAGENT];

    logic [NB_WRAGENT-1:0]  arb_grant;
    logic [AGENT_WIDTH-1:0] arb_idx;
    logic                   arb_any;
    logic [NB_WRAGENT-1:0]  grant_eff;
    logic [AGENT_WIDTH-1:0] grant_idx_eff;
    logic                   grant_any_eff;
    logic                   xfer;
    logic                   sweep_last;

    for (genvar gi = 0; gi < NB_WRAGENT; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    meduram_rr_arbiter #(
        .N  (NB_WRAGENT),
        .IW (AGENT_WIDTH)
    ) u_arb (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req         (req_valid),
        .advance     (xfer),
        .advance_idx (grant_idx_eff),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_any   (arb_any)
    );

`ifdef MEDURAM_WRARB_LOCK_EN
    logic                   lock_reg;
    logic [AGENT_WIDTH-1:0] lock_idx_reg;
    logic                   lock_hit;

    assign lock_hit = lock_reg & req_valid[lock_idx_reg];

    always_comb begin
        grant_eff     = arb_grant;
        grant_idx_eff = arb_idx;
        grant_any_eff = arb_any;
        if (lock_hit) begin
            grant_eff               = '0;
            grant_eff[lock_idx_reg] = 1'b1;
            grant_idx_eff           = lock_idx_reg;
            grant_any_eff           = 1'b1;
        end
    end

    // Every transfer re-decides the lock; an idle locked agent drops it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
        end else if (clear) begin
            lock_reg <= 1'b0;
        end else if (xfer) begin
            lock_reg     <= req_lock[grant_idx_eff];
            lock_idx_reg <= grant_idx_eff;
        end else if (lock_reg && !req_valid[lock_idx_reg]) begin
            lock_reg <= 1'b0;
        end
    end
`else
    assign grant_eff     = arb_grant;
    assign grant_idx_eff = arb_idx;
    assign grant_any_eff = arb_any;
`endif

    // init_done lags RUN by a cycle and drops with clear, so ready is never
    // offered while the sweep is pending or running.
    assign req_ready  = {NB_WRAGENT{init_done_reg}} & grant_eff;
    assign xfer       = init_done_reg & grant_any_eff;
    assign sweep_last = (counter_reg == ADDR_WIDTH'(RAM_DEPTH - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT: begin
                if (!clear && sweep_last) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    state_next = INIT;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= INIT;
            counter_reg    <= '0;
            init_done_reg  <= 1'b0;
            mem_wren_reg   <= 1'b0;
            mem_wraddr_reg <= '0;
            mem_wrdata_reg <= '0;
            mem_agent_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            init_done_reg <= (state_reg == RUN) & ~clear;
            if (state_reg == INIT) begin
                mem_wren_reg   <= 1'b1;
                mem_wraddr_reg <= counter_reg;
                mem_wrdata_reg <= '0;
                mem_agent_reg  <= '0;
                counter_reg    <= (sweep_last || clear) ? '0 : counter_reg + ADDR_WIDTH'(1);
            end else begin
                counter_reg  <= '0;
                mem_wren_reg <= xfer;
                if (xfer) begin
                    mem_wraddr_reg <= addr_arr[grant_idx_eff];
                    mem_wrdata_reg <= data_arr[grant_idx_eff];
                    mem_agent_reg  <= grant_idx_eff;
                end
            end
        end
    end

    assign mem_wren   = mem_wren_reg;
    assign mem_wraddr = mem_wraddr_reg;
    assign mem_wrdata = mem_wrdata_reg;
    assign mem_agent  = mem_agent_reg;
    assign init_done  = init_done_reg;

endmodule

// File: tb/tb_meduram_wrarb.sv
// Directed self-checking bench for meduram_wrarb (3 agents, 16-row bank).
module tb_meduram_wrarb;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int NB = 3;
    localparam int GW = 2;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              clear = 1'b0;
    logic [NB-1:0]     req_valid = '0;
    logic [NB-1:0]     req_ready;
    logic [NB*AW-1:0]  req_addr = '0;
    logic [NB*DW-1:0]  req_data = '0;
`ifdef MEDURAM_WRARB_LOCK_EN
    logic [NB-1:0]     req_lock = '0;
`endif
    logic              mem_wren;
    logic [AW-1:0]     mem_wraddr;
    logic [DW-1:0]     mem_wrdata;
    logic [GW-1:0]     mem_agent;
    logic              init_done;

    int n_cmp = 0;
    int n_err = 0;

    meduram_wrarb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RAM_DEPTH  (DEPTH),
        .NB_WRAGENT (NB)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
`ifdef MEDURAM_WRARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .mem_wren   (mem_wren),
        .mem_wraddr (mem_wraddr),
        .mem_wrdata (mem_wrdata),
        .mem_agent  (mem_agent),
        .init_done  (init_done)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_agent(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic check_write(input string tag, input int agent, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
        check({tag, "_wren"}, mem_wren, 1'b1);
        check({tag, "_agent"}, mem_agent, agent);
        check({tag, "_addr"}, mem_wraddr, a);
        check({tag, "_data"}, mem_wrdata, d);
        $display("write %s: agent=%0d addr=%0h data=%0h", tag, mem_agent, mem_wraddr, mem_wrdata);
    endtask

    initial begin
        logic [2:0] onehot;
`ifdef MEDURAM_WRARB_LOCK_EN
        int lock_seq [5] = '{1, 1, 1, 1, 0};
`endif
        // Reset, with every agent requesting to show ready is held off.
        req_valid = '1;
        repeat (3) step();
        check("rst_wren", mem_wren, 1'b0);
        check("rst_addr", mem_wraddr, 0);
        check("rst_data", mem_wrdata, 0);
        check("rst_agent", mem_agent, 0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_ready", req_ready, 3'b000);

        aresetn = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            step();
            check_write("sweep", 0, AW'(k), '0);
            check("sweep_ready", req_ready, 3'b000);
        end
        check("sweep_last_init_done", init_done, 1'b0);
        req_valid = '0;
        step();
        check("init_done_rise", init_done, 1'b1);
        check("post_sweep_wren", mem_wren, 1'b0);

        // Round robin with every agent valid: grants rotate 0,1,2,0,1,2.
        for (int i = 0; i < NB; i++) set_agent(i, AW'(8'h30 + i), DW'(i));
        req_valid = '1;
        for (int j = 0; j < 6; j++) begin
            #1;
            onehot = 3'b001 << (j % 3);
            check("rr_ready", req_ready, onehot);
            step();
            check_write("rr", j % 3, AW'(8'h30 + j % 3), DW'(j % 3));
        end
        req_valid = '0;

        // Agent 1 alone, back-to-back.
        for (int j = 0; j < 4; j++) begin
            set_agent(1, AW'(8'h10 + j), DW'(32'hA0 + j));
            req_valid = 3'b010;
            #1;
            check("solo_ready", req_ready, 3'b010);
            step();
            check_write("solo", 1, AW'(8'h10 + j), DW'(32'hA0 + j));
        end
        // Pointer sits at 2; agent 0 beats agent 1 on wrap.
        set_agent(0, 8'h50, 32'hB0);
        req_valid = 3'b011;
        #1;
        check("wrap_ready", req_ready, 3'b001);
        step();
        check_write("wrap", 0, 8'h50, 32'hB0);
        set_agent(2, 8'h60, 32'hC0);
        req_valid = 3'b100;
        #1;
        check("a2_ready", req_ready, 3'b100);
        step();
        check_write("a2", 2, 8'h60, 32'hC0);

        // Same address from agents 0 and 2: serialized, agent 0 first.
        set_agent(0, 8'h20, 32'h1111);
        set_agent(2, 8'h20, 32'h2222);
        req_valid = 3'b101;
        #1;
        check("coll_ready0", req_ready, 3'b001);
        step();
        check_write("coll0", 0, 8'h20, 32'h1111);
        req_valid = 3'b100;
        #1;
        check("coll_ready2", req_ready, 3'b100);
        step();
        check_write("coll2", 2, 8'h20, 32'h2222);
        req_valid = '0;
        step();
        check("idle_wren", mem_wren, 1'b0);
        check("idle_addr_hold", mem_wraddr, 8'h20);
        check("idle_data_hold", mem_wrdata, 32'h2222);

        // Clear together with an accepted agent-1 transfer.
        set_agent(1, 8'h44, 32'h55);
        req_valid = 3'b010;
        clear = 1'b1;
        #1;
        check("clr_ready", req_ready, 3'b010);
        step();
        clear = 1'b0;
        req_valid = '1;
        check_write("clr_xfer", 1, 8'h44, 32'h55);
        check("clr_init_done", init_done, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            step();
            check_write("resweep", 0, AW'(k), '0);
            check("resweep_ready", req_ready, 3'b000);
        end
        req_valid = '0;
        step();
        check("reinit_done", init_done, 1'b1);

`ifdef MEDURAM_WRARB_LOCK_EN
        // Move the pointer to 1, then agent 1 holds the port with a lock.
        set_agent(0, 8'h70, 32'h0);
        req_valid = 3'b001;
        #1;
        check("lk_pre_ready", req_ready, 3'b001);
        step();
        check_write("lk_pre", 0, 8'h70, 32'h0);
        set_agent(1, 8'h71, 32'h1);
        req_valid = 3'b011;
        req_lock = 3'b010;
        for (int j = 0; j < 5; j++) begin
            if (j == 3) req_lock = '0;
            step();
            check_write("lock", lock_seq[j], AW'(8'h70 + lock_seq[j]), DW'(lock_seq[j]));
        end
        req_valid = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/meduram_wrarb.md
Name: meduram_wrarb

Overview:
- Write-port arbiter and initializer for one meduram memory bank.
- Shares a single RAM write port between NB_WRAGENT requesters using round-robin valid/ready arbitration.
- Drives registered write commands (address, data, agent index) to the bank and to the per-row last-writer tracking logic.
- After reset or on clear request, sweeps the whole bank with zeros before accepting traffic.

Parameters:
- ADDR_WIDTH, 8, write address width
- DATA_WIDTH, 32, write data width
- RAM_DEPTH, 2**ADDR_WIDTH, number of rows swept during init
- NB_WRAGENT, 2, number of write requesters (1..8)
- AGENT_WIDTH, (NB_WRAGENT==1 ? 1 : $clog2(NB_WRAGENT)), agent index width

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- clear  in  1  pulse: re-run zero sweep
- req_valid  in  NB_WRAGENT  per-agent write request
- req_ready  out  NB_WRAGENT  per-agent accept
- req_addr  in  NB_WRAGENT*ADDR_WIDTH  packed addresses; agent i at [i*ADDR_WIDTH+:ADDR_WIDTH]
- req_data  in  NB_WRAGENT*DATA_WIDTH  packed data
- mem_wren  out  1  registered write enable
- mem_wraddr  out  ADDR_WIDTH  registered write address
- mem_wrdata  out  DATA_WIDTH  registered write data
- mem_agent  out  AGENT_WIDTH  index of agent owning the write; 0 during init
- init_done  out  1  high in RUN state

Behaviour:
- Clock and reset: clock aclk; reset aresetn, asynchronous, active-low.
- Reset values: mem_wren=0, mem_wraddr=0, mem_wrdata=0, mem_agent=0, init_done=0, req_ready=0, rr pointer=0, sweep counter=0, state=INIT.
- FSM, two states:
  - INIT: each cycle mem_wren<=1, mem_wraddr<=counter, mem_wrdata<=0, mem_agent<=0; counter++.
  - INIT exits to RUN in the cycle that issues address RAM_DEPTH-1. The counter is reset to 0 on exit.
  - init_done is registered and rises in the cycle after the last sweep write is presented.
  - RUN: arbitration active. clear=1 moves the FSM to INIT next cycle. A transfer accepted in the same cycle as clear is still issued, and the sweep begins the cycle after it.
  - clear during INIT restarts the counter at 0.
- Arbitration (RUN only):
  - Grant goes to the first agent with req_valid=1, searching from the rr pointer upward with wrap modulo NB_WRAGENT.
  - Exactly one grant per cycle.
  - req_ready[i] = init_done & grant[i]. This is combinational from req_valid; agents must not make valid depend on ready.
  - req_ready is all-zero in INIT.
- Transfer: req_valid[i]&req_ready[i]. The next cycle presents mem_wren=1, mem_wraddr/mem_wrdata = agent i fields, mem_agent=i. Latency is 1 cycle, throughput 1 write per cycle.
- No transfer in a cycle: mem_wren<=0; addr and data hold their last values.
- Pointer update: only on a transfer, to (i+1) mod NB_WRAGENT; it stays put when idle. NB_WRAGENT=1: pointer is constant 0, and agent 0 is granted whenever valid.
- Fairness: with all agents continuously valid, grants rotate 0,1,..,N-1,0. No starvation beyond N-1 cycles.
- Same-address requests from different agents are serialized by arbitration; the bank never sees a write collision.
- Reset mid-operation: everything returns to reset values immediately, and the sweep restarts.

Optional Feature:
- Macro: MEDURAM_WRARB_LOCK_EN.
- Defined:
  - Adds input req_lock [NB_WRAGENT].
  - A transfer with req_lock[i]=1 sets a lock on agent i. While locked, agent i is granted whenever req_valid[i]=1, ignoring the pointer.
  - The lock is released by a transfer with req_lock[i]=0, by req_valid[i]=0, or by clear/reset.
  - The pointer updates normally on release.
- Undefined: no req_lock port; pure round-robin.

Decomposition:
- Package meduram_pkg holds:
  - typedef wrarb_state_t {INIT, RUN}
  - function agent_width(n) returning the AGENT_WIDTH rule
  - a localparam for the maximum NB_WRAGENT=8
- Sub-module meduram_rr_arbiter: combinational request/pointer to one-hot grant plus grant index, together with the registered pointer. It is reusable by a future read-port scheduler.

Test Plan:
- Reset with RAM_DEPTH=16 -> all outputs 0. After release: 16 consecutive cycles of mem_wren=1 with addresses 0..15 and data 0; init_done=1 on cycle 17; req_ready=0 throughout.
- NB_WRAGENT=3, all valid continuously, data=agent id -> mem_agent sequence 0,1,2,0,1,2. Each req_ready pulses exactly once per 3 cycles.
- Only agent 1 valid for 4 cycles, addrs 0x10..0x13 -> 4 back-to-back writes 1 cycle later, mem_agent=1. Then agent 0 requests and is granted next.
- Agents 0 and 2 write addr 0x20 in the same cycle -> two writes on consecutive cycles, agent 0 first then agent 2; mem_wren never carries both.
- clear asserted alongside an accepted agent-1 transfer -> that write is issued, then init_done=0, and a full 0..RAM_DEPTH-1 sweep follows; req_ready stays 0 until the sweep completes.
- With MEDURAM_WRARB_LOCK_EN, NB=2, both valid, agent 1 with lock=1 for 3 transfers then lock=0 -> mem_agent sequence 1,1,1,1,0.
